polyphase_coeff_ctrl: RTL and testbench

Controller that sequences the polyphase FIR datapath. It generates the phase index that selects the active sub-filter, and a strobe marking each new input sample. It also owns a double-buffered coefficient bank. Coefficients are streamed into a shadow bank over a valid/ready handshake and swapped into the active bank only at a phase-0 boundary, so the filter never runs with a mixed coefficient set.

---
 rtl/polyphase_coeff_ctrl.sv | 131 +++++++++++++
 tb/tb_polyphase_coeff_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_coeff_ctrl.sv
// rtl/polyphase_coeff_ctrl.sv - polyphase FIR phase sequencer with double-buffered coefficient bank
module polyphase_coeff_ctrl #(
    parameter int NB_COEFF = 8,
    parameter int N_BAUD   = 6,
    parameter int N_OS     = 4,
    parameter int NB_PHASE = 2,
    parameter int NB_ADDR  = 5
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_coeff_valid,
    input  logic [NB_COEFF-1:0]               i_coeff_data,
    output logic                              o_coeff_ready,
    input  logic                              i_commit,
    output logic [NB_PHASE-1:0]               o_phase,
    output logic                              o_sample_strobe,
    output logic [NB_COEFF*N_BAUD*N_OS-1:0]   o_coeff,
    output logic                              o_swap_done
);

    localparam int N_TAPS  = N_BAUD * N_OS;
    localparam int NB_BANK = NB_COEFF * N_TAPS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_PEND
    } state_t;

    state_t               state_q, state_d;
    logic [NB_PHASE-1:0]  phase_q, phase_d;
    logic                 strobe_q, strobe_d;
    logic                 swap_done_q, swap_done_d;
    logic [NB_ADDR-1:0]   idx_q, idx_d;
    logic [NB_BANK-1:0]   shadow_q, shadow_d;
    logic [NB_BANK-1:0]   active_q, active_d;

    logic wrap;
    logic ready;
    logic accept;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            strobe_q    <= 1'b0;
            swap_done_q <= 1'b0;
            idx_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            strobe_q    <= strobe_d;
            swap_done_q <= swap_done_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        wrap     = i_enable && (phase_q == NB_PHASE'(N_OS - 1));
        strobe_d = wrap;
        if (!i_enable) begin
            phase_d = phase_q;
        end else if (wrap) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + NB_PHASE'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        swap_done_d = 1'b0;
        ready       = (state_q == ST_LOAD);
        accept      = ready && i_coeff_valid;

        // Decode the write slot per tap so the index never drives a variable part-select.
        for (int k = 0; k < N_TAPS; k++) begin
            if (accept && (idx_q == NB_ADDR'(k))) begin
                shadow_d[k*NB_COEFF +: NB_COEFF] = i_coeff_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept) begin
                    if (idx_q == NB_ADDR'(N_TAPS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_FULL;
                    end else begin
                        idx_d = idx_q + NB_ADDR'(1);
                    end
                end
            end
            ST_FULL: begin
                if (i_commit) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Swapping on the wrap edge lands new taps in the strobe cycle at phase 0.
                if (wrap) begin
                    active_d    = shadow_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_coeff_ready   = ready;
    assign o_phase         = phase_q;
    assign o_sample_strobe = strobe_q;
    assign o_coeff         = active_q;
    assign o_swap_done     = swap_done_q;

endmodule

// File: tb/tb_polyphase_coeff_ctrl.sv
// tb/tb_polyphase_coeff_ctrl.sv - self-checking bench for polyphase_coeff_ctrl
module tb_polyphase_coeff_ctrl;

    localparam int NB_COEFF = 8;
    localparam int N_BAUD   = 6;
    localparam int N_OS     = 4;
    localparam int NB_PHASE = 2;
    localparam int NB_ADDR  = 5;
    localparam int N_TAPS   = N_BAUD * N_OS;
    localparam int NB_BANK  = NB_COEFF * N_TAPS;

    logic                clk = 1'b1;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                valid = 1'b0;
    logic [NB_COEFF-1:0] data = '0;
    logic                commit = 1'b0;
    logic                ready;
    logic [NB_PHASE-1:0] phase;
    logic                strobe;
    logic [NB_BANK-1:0]  coeff;
    logic                swap_done;

    polyphase_coeff_ctrl #(
        .NB_COEFF(NB_COEFF), .N_BAUD(N_BAUD), .N_OS(N_OS),
        .NB_PHASE(NB_PHASE), .NB_ADDR(NB_ADDR)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_enable(en),
        .i_coeff_valid(valid),
        .i_coeff_data(data),
        .o_coeff_ready(ready),
        .i_commit(commit),
        .o_phase(phase),
        .o_sample_strobe(strobe),
        .o_coeff(coeff),
        .o_swap_done(swap_done)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int swaps_seen = 0;

    task automatic chk(input string nm, input logic [NB_BANK-1:0] act, input logic [NB_BANK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts loaded words and tracks a pending commit.
    int                  m_phase;
    bit                  m_strobe, m_swap, m_started, m_pend;
    int                  m_n;
    logic [NB_COEFF-1:0] m_shadow [N_TAPS];
    logic [NB_COEFF-1:0] m_active [N_TAPS];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_strobe = 0; m_swap = 0; m_started = 0; m_pend = 0; m_n = 0;
            for (int k = 0; k < N_TAPS; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
        end else begin
            bit wrap, rdy;
            wrap = en && (m_phase == N_OS - 1);
            rdy  = m_started && (m_n < N_TAPS) && !m_pend;
            m_strobe = wrap;
            m_swap   = 0;
            if (m_pend && wrap) begin
                for (int k = 0; k < N_TAPS; k++) m_active[k] = m_shadow[k];
                m_pend = 0;
                m_n    = 0;
                m_swap = 1;
            end else if (!m_pend && m_n == N_TAPS && commit) begin
                m_pend = 1;
            end
            if (rdy && valid) begin
                m_shadow[m_n] = data;
                m_n++;
            end
            m_started = 1;
            if (en) m_phase = (m_phase + 1) % N_OS;
        end
    end

    function automatic logic [NB_BANK-1:0] model_bank();
        logic [NB_BANK-1:0] b;
        for (int k = 0; k < N_TAPS; k++) b[k*NB_COEFF +: NB_COEFF] = m_active[k];
        return b;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase", NB_BANK'(phase), NB_BANK'(m_phase));
            chk("strobe", NB_BANK'(strobe), NB_BANK'(m_strobe));
            chk("swap_done", NB_BANK'(swap_done), NB_BANK'(m_swap));
            chk("ready", NB_BANK'(ready), NB_BANK'(m_started && m_n < N_TAPS && !m_pend));
            chk("coeff", coeff, model_bank());
            if (swap_done === 1'b1) swaps_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_all(input int base, input bit use_index, input bit gaps);
        for (int k = 0; k < N_TAPS; k++) begin
            data  = use_index ? NB_COEFF'(base + k) : NB_COEFF'(base);
            valid = 1'b1;
            step(1);
            if (gaps) begin
                valid = 1'b0;
                data  = 8'hEE;
                step(1 + (k % 2));
            end
        end
        valid = 1'b0;
    endtask

    task automatic wait_swap(input string nm);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (swap_done === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errs++;
            $display("FAIL %s: swap_done not seen within 40 cycles", nm);
        end
    endtask

    initial begin
        int strobes;
        #5 rst = 1'b1;
        #1;
        chk("rst_phase", NB_BANK'(phase), '0);
        chk("rst_strobe", NB_BANK'(strobe), '0);
        chk("rst_ready", NB_BANK'(ready), '0);
        chk("rst_swap", NB_BANK'(swap_done), '0);
        chk("rst_coeff", coeff, '0);
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1);
        chk("ready_after_idle", NB_BANK'(ready), NB_BANK'(1));

        en = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (strobe === 1'b1) begin
                strobes++;
                chk("strobe_at_phase0", NB_BANK'(phase), '0);
            end
        end
        chk("strobe_count", NB_BANK'(strobes), NB_BANK'(2));
        chk("phase_before_freeze", NB_BANK'(phase), NB_BANK'(2));
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("phase_frozen", NB_BANK'(phase), NB_BANK'(2));
            chk("no_strobe_frozen", NB_BANK'(strobe), '0);
        end

        load_all(0, 1, 0);
        chk("ready_full", NB_BANK'(ready), '0);
        chk("coeff_still_zero", coeff, '0);
        en = 1'b1;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        wait_swap("swap1");
        chk("swap1_phase", NB_BANK'(phase), '0);
        chk("swap1_strobe", NB_BANK'(strobe), NB_BANK'(1));
        chk("swap1_ready", NB_BANK'(ready), NB_BANK'(1));
        chk("swap1_tap0", NB_BANK'(coeff[0 +: 8]), NB_BANK'(0));
        chk("swap1_tap7", NB_BANK'(coeff[7*8 +: 8]), NB_BANK'(7));
        chk("swap1_tap23", NB_BANK'(coeff[23*8 +: 8]), NB_BANK'(23));

        for (int k = 0; k < 10; k++) begin
            data = NB_COEFF'(100 + k);
            valid = 1'b1;
            step(1);
        end
        valid = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(8);
        chk("partial_no_swap", NB_BANK'(coeff[0 +: 8]), NB_BANK'(0));
        for (int k = 10; k < N_TAPS; k++) begin
            data = NB_COEFF'(100 + k);
            valid = 1'b1;
            step(1);
            valid = 1'b0;
            step(1 + (k % 3));
        end
        chk("full_after_gaps", NB_BANK'(ready), '0);

        data = 8'h7F;
        valid = 1'b1;
        step(5);
        valid = 1'b0;
        en = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(20);
        chk("no_swap_disabled", NB_BANK'(coeff[23*8 +: 8]), NB_BANK'(23));
        en = 1'b1;
        wait_swap("swap2");
        chk("swap2_tap0", NB_BANK'(coeff[0 +: 8]), NB_BANK'(100));
        chk("swap2_tap23", NB_BANK'(coeff[23*8 +: 8]), NB_BANK'(123));

        load_all(8'h55, 0, 0);
        en = 1'b0;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        chk("rst_pend_coeff", coeff, '0);
        chk("rst_pend_ready", NB_BANK'(ready), '0);
        step(2);
        rst = 1'b0;
        step(1);
        load_all(8'h80, 0, 1);
        en = 1'b1;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        wait_swap("swap3");
        for (int k = 0; k < N_TAPS; k++) begin
            chk("swap3_tap", NB_BANK'(coeff[k*8 +: 8]), NB_BANK'(8'h80));
        end
        step(4);
        chk("swap_pulse_count", NB_BANK'(swaps_seen), NB_BANK'(3));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
